// File: rtl/array_12_ctrl.sv
// array_12_ctrl: round-robin arbiter and sequencer that shares one masked
// single-port array between requesters A and B and returns read data on
// per-requester response strobes.
//
// Build option: define ARRAY_12_INIT_EN to zero-fill every entry after reset.
// While the fill runs, busy is high and neither requester is granted.
//
// Handshake: a command is accepted in any cycle where req_valid && req_ready.
// Ready may be high without valid. At most one requester is accepted per
// cycle. An accepted command drives the array in that same cycle. Responses
// are single-cycle pulses one cycle after a read is accepted. They cannot be
// back-pressured.
module array_12_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 30,
  parameter int MASK_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_wr,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [MASK_W-1:0] a_req_mask,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_wr,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [MASK_W-1:0] b_req_mask,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_wmode,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [MASK_W-1:0] ram_wmask,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Identity of a requester. Used both for the round-robin history and for
  // the owner of an in-flight read.
  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;

  // The address width must be able to reach every entry.
  if (DEPTH > (1 << ADDR_W)) begin : g_addr_too_narrow
  end

  grant_e            r_last_grant;
  grant_e            r_owner;
  logic              r_pend;
  logic              w_busy;
  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_a_acc;
  logic              w_b_acc;

`ifdef ARRAY_12_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              r_busy;
  logic [ADDR_W-1:0] r_init_addr;

  // Zero-fill sweep: one entry per cycle from address 0, then release busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b1;
      r_init_addr <= '0;
    end else if (r_busy) begin
      r_init_addr <= r_init_addr + 1'b1;
      if (r_init_addr == LAST_ADDR) r_busy <= 1'b0;
    end
  end

  // The sweep drives the port only once reset has been released.
  assign w_busy      = r_busy;
  assign w_init_we   = r_busy & rst_n;
  assign w_init_addr = r_init_addr;
`else
  assign w_busy      = 1'b0;
  assign w_init_we   = 1'b0;
  assign w_init_addr = '0;
`endif

  // Round-robin readies, accepts and the array port multiplexer.
  always_comb begin
    a_req_ready = !w_busy && (!b_req_valid || (r_last_grant == GNT_B));
    b_req_ready = !w_busy && (!a_req_valid || (r_last_grant == GNT_A));
    w_a_acc     = a_req_valid && a_req_ready;
    w_b_acc     = b_req_valid && b_req_ready;
    ram_en      = 1'b0;
    ram_wmode   = 1'b0;
    ram_addr    = '0;
    ram_wmask   = '0;
    ram_wdata   = '0;
    if (w_init_we) begin
      ram_en    = 1'b1;
      ram_wmode = 1'b1;
      ram_addr  = w_init_addr;
      ram_wmask = '1;
    end else if (w_a_acc) begin
      ram_en    = 1'b1;
      ram_wmode = a_req_wr;
      ram_addr  = a_req_addr;
      ram_wmask = a_req_wr ? a_req_mask : '0;
      ram_wdata = a_req_wdata;
    end else if (w_b_acc) begin
      ram_en    = 1'b1;
      ram_wmode = b_req_wr;
      ram_addr  = b_req_addr;
      ram_wmask = b_req_wr ? b_req_mask : '0;
      ram_wdata = b_req_wdata;
    end
  end

  // Remember the most recent winner so the other side wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GNT_B;
    end else if (w_a_acc) begin
      r_last_grant <= GNT_A;
    end else if (w_b_acc) begin
      r_last_grant <= GNT_B;
    end
  end

  // Track the read in flight: it returns the cycle after it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_owner <= GNT_A;
    end else begin
      r_pend <= (w_a_acc && !a_req_wr) || (w_b_acc && !b_req_wr);
      if (w_a_acc && !a_req_wr) r_owner <= GNT_A;
      else if (w_b_acc && !b_req_wr) r_owner <= GNT_B;
    end
  end

  assign busy        = w_busy;
  assign a_rsp_valid = r_pend && (r_owner == GNT_A);
  assign b_rsp_valid = r_pend && (r_owner == GNT_B);
  assign a_rsp_rdata = a_rsp_valid ? ram_rdata : '0;
  assign b_rsp_rdata = b_rsp_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_array_12_ctrl.sv
// Testbench for array_12_ctrl. A behavioural array model answers the DUT's
// port. A reference model predicts grants, port activity and read data from
// the arbitration rules. A monitor pops expected responses and compares them.
module tb_array_12_ctrl;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 30;
  localparam int MASK_W = 2;
  localparam int SEG_W  = DATA_W / MASK_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a_req_valid = 1'b0, a_req_wr = 1'b0;
  logic [ADDR_W-1:0] a_req_addr = '0;
  logic [MASK_W-1:0] a_req_mask = '0;
  logic [DATA_W-1:0] a_req_wdata = '0;
  logic              b_req_valid = 1'b0, b_req_wr = 1'b0;
  logic [ADDR_W-1:0] b_req_addr = '0;
  logic [MASK_W-1:0] b_req_mask = '0;
  logic [DATA_W-1:0] b_req_wdata = '0;
  logic              a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, busy;
  logic [DATA_W-1:0] a_rsp_rdata, b_rsp_rdata;
  logic              ram_en, ram_wmode;
  logic [ADDR_W-1:0] ram_addr;
  logic [MASK_W-1:0] ram_wmask;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit in_init = 1'b0;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                m_last = 1'b1;   // 1 = B won last
  logic [DATA_W-1:0] exp_a_q[$];
  logic [DATA_W-1:0] exp_b_q[$];
  int                due_a_q[$];
  int                due_b_q[$];

  array_12_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wr(a_req_wr),
    .a_req_addr(a_req_addr), .a_req_mask(a_req_mask), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wr(b_req_wr),
    .b_req_addr(b_req_addr), .b_req_mask(b_req_mask), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .busy(busy), .ram_en(ram_en), .ram_wmode(ram_wmode), .ram_addr(ram_addr),
    .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural array ----------------
  logic [DATA_W-1:0] tb_mem [DEPTH];
  logic [DATA_W-1:0] wr_bits;
  assign wr_bits = {{SEG_W{ram_wmask[1]}}, {SEG_W{ram_wmask[0]}}};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wmode) tb_mem[ram_addr] <= (tb_mem[ram_addr] & ~wr_bits) | (ram_wdata & wr_bits);
      else           ram_rdata <= tb_mem[ram_addr];
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] apply_mask(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = old;
    for (int s = 0; s < MASK_W; s++)
      if (m[s]) for (int b = 0; b < SEG_W; b++) r[s*SEG_W+b] = d[s*SEG_W+b];
    return r;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_accept(input bit who, input bit wr, input logic [ADDR_W-1:0] addr,
      input logic [MASK_W-1:0] mask, input logic [DATA_W-1:0] d);
    chk("ram_en", 32'(ram_en), 32'd1);
    chk("ram_wmode", 32'(ram_wmode), 32'(wr));
    chk("ram_addr", 32'(ram_addr), 32'(addr));
    chk("ram_wmask", 32'(ram_wmask), wr ? 32'(mask) : 32'd0);
    chk("ram_wdata", 32'(ram_wdata), 32'(d));
    m_last = who;
    if (wr) begin
      ref_mem[addr] = apply_mask(ref_mem[addr], d, mask);
    end else if (!who) begin
      exp_a_q.push_back(ref_mem[addr]);
      due_a_q.push_back(cyc + 1);
    end else begin
      exp_b_q.push_back(ref_mem[addr]);
      due_b_q.push_back(cyc + 1);
    end
  endtask

  always @(negedge clk) begin
    bit ra, rb;
    if (!rst_n) begin
      m_last = 1'b1;
    end else if (!in_init) begin
      ra = !b_req_valid || m_last;
      rb = !a_req_valid || !m_last;
      chk("a_req_ready", 32'(a_req_ready), 32'(ra));
      chk("b_req_ready", 32'(b_req_ready), 32'(rb));
      if (a_req_valid && ra)
        model_accept(1'b0, a_req_wr, a_req_addr, a_req_mask, a_req_wdata);
      else if (b_req_valid && rb)
        model_accept(1'b1, b_req_wr, b_req_addr, b_req_mask, b_req_wdata);
      else
        chk("ram_en_idle", 32'(ram_en), 32'd0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    bit want_a, want_b;
    if (!rst_n) begin
      exp_a_q.delete(); due_a_q.delete();
      exp_b_q.delete(); due_b_q.delete();
      chk("a_rsp_valid_rst", 32'(a_rsp_valid), 32'd0);
      chk("b_rsp_valid_rst", 32'(b_rsp_valid), 32'd0);
    end else begin
      want_a = (due_a_q.size() > 0) && (due_a_q[0] == cyc);
      want_b = (due_b_q.size() > 0) && (due_b_q[0] == cyc);
      chk("a_rsp_valid", 32'(a_rsp_valid), 32'(want_a));
      chk("b_rsp_valid", 32'(b_rsp_valid), 32'(want_b));
      if (want_a) begin
        chk("a_rsp_rdata", 32'(a_rsp_rdata), 32'(exp_a_q[0]));
        void'(exp_a_q.pop_front()); void'(due_a_q.pop_front());
      end else begin
        chk("a_rsp_rdata_idle", 32'(a_rsp_rdata), 32'd0);
      end
      if (want_b) begin
        chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(exp_b_q[0]));
        void'(exp_b_q.pop_front()); void'(due_b_q.pop_front());
      end else begin
        chk("b_rsp_rdata_idle", 32'(b_rsp_rdata), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_a(input bit v, input bit wr, input logic [ADDR_W-1:0] addr,
      input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    a_req_valid = v; a_req_wr = wr; a_req_addr = addr; a_req_mask = m; a_req_wdata = d;
  endtask

  task automatic drive_b(input bit v, input bit wr, input logic [ADDR_W-1:0] addr,
      input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    b_req_valid = v; b_req_wr = wr; b_req_addr = addr; b_req_mask = m; b_req_wdata = d;
  endtask

  task automatic idle();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    #1;
    chk("ram_en_in_rst", 32'(ram_en), 32'd0);
    chk("a_rsp_valid_in_rst", 32'(a_rsp_valid), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
`ifdef ARRAY_12_INIT_EN
    in_init = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("init_busy", 32'(busy), 32'd1);
      chk("init_ram_en", 32'(ram_en), 32'd1);
      chk("init_ram_wmode", 32'(ram_wmode), 32'd1);
      chk("init_ram_addr", 32'(ram_addr), 32'(i));
      chk("init_ram_wmask", 32'(ram_wmask), 32'd3);
      chk("init_ram_wdata", 32'(ram_wdata), 32'd0);
      chk("init_a_ready", 32'(a_req_ready), 32'd0);
      chk("init_b_ready", 32'(b_req_ready), 32'd0);
      step();
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    in_init = 1'b0;
`endif
    #1;
    chk("busy_after_reset", 32'(busy), 32'd0);
    chk("a_ready_after_reset", 32'(a_req_ready), 32'd1);
    chk("b_ready_after_reset", 32'(b_req_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = DATA_W'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    do_reset();

`ifdef ARRAY_12_INIT_EN
    drive_a(1'b1, 1'b0, 3'd5, 2'b00, '0); step(); idle();
    chk("init_read5_valid", 32'(a_rsp_valid), 32'd1);
    chk("init_read5_data", 32'(a_rsp_rdata), 32'd0);
    step();
`endif

    // Single requester write then read
    drive_a(1'b1, 1'b1, 3'd3, 2'b11, 30'h2AAA_AAAA); step();
    drive_a(1'b1, 1'b0, 3'd3, 2'b00, '0); step(); idle();
    chk("single_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("single_rsp_data", 32'(a_rsp_rdata), 32'h2AAA_AAAA);
    chk("single_b_quiet", 32'(b_rsp_valid), 32'd0);
    step();

    // Partial mask: clear only the low segment
    drive_a(1'b1, 1'b1, 3'd1, 2'b11, 30'h3FFF_FFFF); step();
    drive_a(1'b1, 1'b1, 3'd1, 2'b01, 30'h0); step();
    drive_a(1'b1, 1'b0, 3'd1, 2'b00, '0); step(); idle();
    chk("partial_mask_data", 32'(a_rsp_rdata), 32'h3FFF_8000);
    step();

    // Contention after reset: A first, then strict alternation
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, 1'b0, ADDR_W'(i), 2'b00, '0);
      drive_b(1'b1, 1'b0, ADDR_W'(7 - i), 2'b00, '0);
      #1;
      chk("contend_a_ready", 32'(a_req_ready), 32'(i % 2 == 0));
      chk("contend_b_ready", 32'(b_req_ready), 32'(i % 2 == 1));
      step();
    end
    idle(); step();

    // Read/write interleave on the same address
    drive_b(1'b1, 1'b1, 3'd2, 2'b11, 30'h11); step();
    drive_b(1'b1, 1'b0, 3'd2, 2'b00, '0); step();
    idle();
    drive_a(1'b1, 1'b1, 3'd2, 2'b11, 30'h22);
    #1;
    chk("interleave_b_valid", 32'(b_rsp_valid), 32'd1);
    chk("interleave_b_data", 32'(b_rsp_rdata), 32'h11);
    step();
    drive_a(1'b1, 1'b0, 3'd2, 2'b00, '0); step(); idle();
    chk("interleave_later_read", 32'(a_rsp_rdata), 32'h22);
    step();

    // Reset arriving the cycle after a read accept drops the response
    drive_a(1'b1, 1'b0, 3'd3, 2'b00, '0); step();
    rst_n = 1'b0;
    #1;
    chk("reset_drops_rsp", 32'(a_rsp_valid), 32'd0);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
              MASK_W'($urandom_range(0, 3)), DATA_W'($urandom));
      drive_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
              MASK_W'($urandom_range(0, 3)), DATA_W'($urandom));
      step();
    end
    idle();
    repeat (3) step();
    chk("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/array_12_ctrl.md
# array_12_ctrl

Two-requester arbiter and sequencer for the 8-entry × 30-bit single-port masked array (one RW port, 2 mask segments of 15 bits, read data one cycle after a read-enable). It shares the single RW port between requester A and requester B with fair round-robin arbitration. It returns read data on per-requester response strobes. It can optionally zero-fill the array after reset before granting any request.

## Interface
Parameters:
- DEPTH, 8, number of array entries
- ADDR_W, 3, address width (log2 DEPTH)
- DATA_W, 30, data width
- MASK_W, 2, write-mask segments (DATA_W/MASK_W bits each)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req_valid  in  1  requester A command valid
- a_req_ready  out  1  requester A command accepted this cycle when valid
- a_req_wr  in  1  1 = write, 0 = read
- a_req_addr  in  ADDR_W  entry address
- a_req_mask  in  MASK_W  write segment enables (ignored on reads)
- a_req_wdata  in  DATA_W  write data
- a_rsp_valid  out  1  read data for A valid (single-cycle pulse)
- a_rsp_rdata  out  DATA_W  read data for A
- b_req_valid, b_req_ready, b_req_wr, b_req_addr, b_req_mask, b_req_wdata, b_rsp_valid, b_rsp_rdata: same as A, for requester B
- busy  out  1  init sequence in progress
- ram_en  out  1  array port enable
- ram_wmode  out  1  array write mode
- ram_addr  out  ADDR_W  array address
- ram_wmask  out  MASK_W  array write mask
- ram_wdata  out  DATA_W  array write data
- ram_rdata  in  DATA_W  array read data

## Operation
- Accept means valid && ready. At most one accept per cycle.
- Ready equations, when not busy:
  - a_req_ready = !busy && (!b_req_valid || last_grant==B)
  - b_req_ready = !busy && (!a_req_valid || last_grant==A)
  - Ready may be high without valid.
- last_grant register: updates to the accepted requester on each accept. Resets to B, so A wins the first contention.
- Accepted command drives the array in the same cycle, combinationally:
  - ram_en=1, ram_wmode=req_wr, ram_addr=req_addr
  - ram_wmask=req_mask on writes, 0 on reads
  - ram_wdata=req_wdata
- No accept: ram_en=0, all other ram_* outputs 0.
- Write with mask 00 is still accepted and issued (no array effect). It produces no response.
- Read accept sets a 1-bit owner register (A/B) and a pending flag. The next cycle, the owner's rsp_valid=1 and its rsp_rdata=ram_rdata. The other requester's rsp_rdata=0.
- Responses cannot be back-pressured. Back-to-back reads give back-to-back responses.
- A write accepted the cycle after a read does not disturb that read's response.

## Timing
- Read latency: accept in cycle N → rsp_valid in cycle N+1. Write latency: array updated at the end of cycle N.
- Throughput: one command per cycle. Under continuous contention, grants alternate A,B,A,B.
- Reset values:
  - a_rsp_valid=b_rsp_valid=0, rsp_rdata=0
  - ram_en=0
  - last_grant=B, pending=0
  - busy per Configuration
- Reset asserted mid-operation: any pending response is dropped (no rsp_valid after reset). An in-progress init restarts from address 0 after deassertion.

## Configuration
- ARRAY_12_INIT_EN defined:
  - busy resets to 1.
  - From the first clk edge after rst_n deassertion, an internal 3-bit counter drives ram_en=1, ram_wmode=1, ram_wmask=11, ram_wdata=0, ram_addr=0..7 over 8 consecutive cycles.
  - busy falls in the cycle after address 7 is written. Both ready outputs are 0 while busy.
- ARRAY_12_INIT_EN undefined:
  - No counter. busy is tied 0.
  - Requests are accepted from the first cycle after reset. Array contents are undefined until written.

## Test plan
- Init (macro on): release reset → busy=1 for exactly 8 cycles, ram_addr 0..7 with wdata 0 and mask 11, readies 0. Then a read of addr 5 returns 0x0000_0000.
- Single requester: A writes addr 3 = 0x2AAA_AAAA mask 11, then reads addr 3 → a_rsp_valid one cycle after accept with 0x2AAA_AAAA. b_rsp_valid stays 0.
- Partial mask: write addr 1 = 0x3FFF_FFFF mask 11, then write 0 with mask 01 → read returns 0x3FFF_8000.
- Contention: A and B both valid reading for 6 cycles → grants A,B,A,B,A,B. Each response pulses on the correct requester one cycle after its grant.
- Read/write interleave: B reads addr 2 (holding 0x11), and A's write of 0x22 to addr 2 is accepted the next cycle → b_rsp_rdata=0x11. A later read returns 0x22.
- Reset mid-flight: assert rst_n low in the cycle after a read accept → no rsp_valid. With the macro on, init reruns from addr 0.
